// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one BRAM port between a display fetcher (priority) and a host,
// with a starvation guard that forces host grants after STARVE_LIMIT waiting cycles.
module bram_arbiter #(
  parameter int ADDR_BITS    = 32,
  parameter int DATA_BITS    = 32,
  parameter int BRAM_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   disp_req_i,
  input  logic [ADDR_BITS-1:0]   disp_addr_i,
  output logic [DATA_BITS-1:0]   disp_data_o,
  output logic                   disp_valid_o,
  input  logic                   host_valid_i,
  output logic                   host_ready_o,
  input  logic [ADDR_BITS-1:0]   host_addr_i,
  input  logic [DATA_BITS-1:0]   host_wdata_i,
  input  logic [DATA_BITS/8-1:0] host_we_i,
  output logic [DATA_BITS-1:0]   host_rdata_o,
  output logic                   host_rvalid_o,
  output logic                   bram_clk_o,
  output logic                   bram_rst_o,
  output logic                   bram_en_o,
  output logic [ADDR_BITS-1:0]   bram_addr_o,
  output logic [DATA_BITS-1:0]   bram_din_o,
  output logic [DATA_BITS/8-1:0] bram_we_o,
  input  logic [DATA_BITS-1:0]   bram_dout_i,
  output logic [15:0]            disp_drop_cnt_o
);
  localparam logic [1:0]  TAG_NONE = 2'd0;
  localparam logic [1:0]  TAG_DISP = 2'd1;
  localparam logic [1:0]  TAG_HOST = 2'd2;
  localparam logic [15:0] LIMIT    = 16'(STARVE_LIMIT);
  logic [BRAM_LATENCY:0][1:0] tag_sr;
  logic [15:0]                wait_cnt;
  logic                       force_host, host_gnt, disp_gnt;
  logic [1:0]                 new_tag, out_tag;
  assign bram_clk_o   = clk_i;
  assign bram_rst_o   = ~reset_i;
  assign force_host   = (STARVE_LIMIT != 0) && host_valid_i && (wait_cnt >= LIMIT);
  assign host_gnt     = host_valid_i && (!disp_req_i || force_host);
  assign disp_gnt     = disp_req_i && !force_host;
  assign host_ready_o = host_gnt;
  assign new_tag      = disp_gnt ? TAG_DISP : (host_gnt && host_we_i == '0) ? TAG_HOST : TAG_NONE;
  assign out_tag      = tag_sr[BRAM_LATENCY];
  // tag_sr[BRAM_LATENCY] lines up with the cycle bram_dout_i carries that access's data
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      bram_en_o       <= 1'b0;
      bram_addr_o     <= '0;
      bram_din_o      <= '0;
      bram_we_o       <= '0;
      tag_sr          <= '0;
      disp_valid_o    <= 1'b0;
      disp_data_o     <= '0;
      host_rvalid_o   <= 1'b0;
      host_rdata_o    <= '0;
      wait_cnt        <= '0;
      disp_drop_cnt_o <= '0;
    end else begin
      bram_en_o     <= host_gnt || disp_gnt;
      bram_addr_o   <= host_gnt ? host_addr_i : disp_addr_i;
      bram_din_o    <= host_gnt ? host_wdata_i : '0;
      bram_we_o     <= host_gnt ? host_we_i : '0;
      tag_sr        <= {tag_sr[BRAM_LATENCY-1:0], new_tag};
      disp_valid_o  <= out_tag == TAG_DISP;
      host_rvalid_o <= out_tag == TAG_HOST;
      if (out_tag == TAG_DISP) disp_data_o <= bram_dout_i;
      if (out_tag == TAG_HOST) host_rdata_o <= bram_dout_i;
      wait_cnt <= host_gnt ? '0 : (host_valid_i && wait_cnt != '1) ? wait_cnt + 16'd1 : wait_cnt;
      if (force_host && disp_req_i && disp_drop_cnt_o != 16'hFFFF)
        disp_drop_cnt_o <= disp_drop_cnt_o + 16'd1;
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed stimulus against a transaction-level model of the arbiter and a BRAM model.
module tb_bram_arbiter;
  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        disp_req_i = 1'b0, host_valid_i = 1'b0;
  logic [31:0] disp_addr_i = '0, host_addr_i = '0, host_wdata_i = '0;
  logic [3:0]  host_we_i = '0;
  logic [31:0] disp_data_o, host_rdata_o, bram_addr_o, bram_din_o, bram_dout;
  logic        disp_valid_o, host_ready_o, host_rvalid_o, bram_clk_o, bram_rst_o, bram_en_o;
  logic [3:0]  bram_we_o;
  logic [15:0] disp_drop_cnt_o;
  logic [31:0] nl_disp_data, nl_host_rdata, nl_addr, nl_din;
  logic        nl_disp_valid, nl_ready, nl_rvalid, nl_bclk, nl_brst, nl_en;
  logic [3:0]  nl_we;
  logic [15:0] nl_drop;

  always #5 clk = ~clk;

  bram_arbiter dut (
    .clk_i(clk), .reset_i(reset_i), .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
    .disp_data_o(disp_data_o), .disp_valid_o(disp_valid_o), .host_valid_i(host_valid_i),
    .host_ready_o(host_ready_o), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_we_i(host_we_i), .host_rdata_o(host_rdata_o), .host_rvalid_o(host_rvalid_o),
    .bram_clk_o(bram_clk_o), .bram_rst_o(bram_rst_o), .bram_en_o(bram_en_o),
    .bram_addr_o(bram_addr_o), .bram_din_o(bram_din_o), .bram_we_o(bram_we_o),
    .bram_dout_i(bram_dout), .disp_drop_cnt_o(disp_drop_cnt_o));

  bram_arbiter #(.STARVE_LIMIT(0)) u_nl (
    .clk_i(clk), .reset_i(reset_i), .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
    .disp_data_o(nl_disp_data), .disp_valid_o(nl_disp_valid), .host_valid_i(host_valid_i),
    .host_ready_o(nl_ready), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_we_i(host_we_i), .host_rdata_o(nl_host_rdata), .host_rvalid_o(nl_rvalid),
    .bram_clk_o(nl_bclk), .bram_rst_o(nl_brst), .bram_en_o(nl_en),
    .bram_addr_o(nl_addr), .bram_din_o(nl_din), .bram_we_o(nl_we),
    .bram_dout_i(bram_dout), .disp_drop_cnt_o(nl_drop));

  // BRAM: content = stored ^ (0x100 + addr), so unwritten words read as addr+0x100
  bit   [31:0] bmem [256];
  logic [31:0] bp;
  always @(posedge clk)
    if (bram_en_o) begin
      bp = 32'h100 + {24'd0, bram_addr_o[7:0]};
      bram_dout <= bmem[bram_addr_o[7:0]] ^ bp;
      for (int b = 0; b < 4; b++)
        if (bram_we_o[b]) bmem[bram_addr_o[7:0]][8*b +: 8] <= bram_din_o[8*b +: 8] ^ bp[8*b +: 8];
    end

  int          n_cmp = 0, n_bad = 0, cyc = 0, m_wait = 0, m_drops = 0;
  int          dv_cnt = 0, hv_cnt = 0, nl_ready_cnt = 0, first;
  logic        last_ready;
  logic [31:0] mmem [256];
  bit          exp_dv [512], exp_hv [512], exp_en [512];
  logic [31:0] exp_dd [512], exp_hd [512];
  logic [3:0]  exp_we [512];
  logic [15:0] exp_drop [512];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One request cycle: model decides the grant from the arbitration rules, then all outputs are compared.
  task automatic tick(input logic dr, input logic [31:0] da, input logic hv, input logic [31:0] ha,
                      input logic [31:0] hd, input logic [3:0] hwe);
    logic fh, hg, dg;
    disp_req_i = dr; disp_addr_i = da; host_valid_i = hv;
    host_addr_i = ha; host_wdata_i = hd; host_we_i = hwe;
    fh = hv && (m_wait >= 8);
    hg = hv && (!dr || fh);
    dg = dr && !fh;
    if (dg) begin exp_dv[cyc+3] = 1; exp_dd[cyc+3] = mmem[da[7:0]]; end
    if (hg && hwe == 4'h0) begin exp_hv[cyc+3] = 1; exp_hd[cyc+3] = mmem[ha[7:0]]; end
    if (hg) for (int b = 0; b < 4; b++) if (hwe[b]) mmem[ha[7:0]][8*b +: 8] = hd[8*b +: 8];
    if (fh && dr) m_drops++;
    m_wait = hg ? 0 : hv ? m_wait + 1 : m_wait;
    exp_en[cyc+1] = hg || dg;
    exp_we[cyc+1] = hg ? hwe : 4'h0;
    exp_drop[cyc+1] = 16'(m_drops);
    @(negedge clk);
    chk("host_ready", host_ready_o, hg);
    chk("nl_ready", nl_ready, hv && !dr);
    chk("nl_drop_cnt", nl_drop, 0);
    chk("disp_valid", disp_valid_o, exp_dv[cyc]);
    if (exp_dv[cyc]) chk("disp_data", disp_data_o, exp_dd[cyc]);
    chk("host_rvalid", host_rvalid_o, exp_hv[cyc]);
    if (exp_hv[cyc]) chk("host_rdata", host_rdata_o, exp_hd[cyc]);
    chk("bram_en", bram_en_o, exp_en[cyc]);
    if (exp_en[cyc]) chk("bram_we", bram_we_o, exp_we[cyc]);
    chk("drop_cnt", disp_drop_cnt_o, exp_drop[cyc]);
    chk("bram_rst", bram_rst_o, 0);
    last_ready = host_ready_o;
    dv_cnt += int'(disp_valid_o);
    hv_cnt += int'(host_rvalid_o);
    nl_ready_cnt += int'(nl_ready);
    @(posedge clk); #1; cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_i = 0; disp_req_i = 0; host_valid_i = 0; host_we_i = 0;
    @(posedge clk); #1;
    chk("rst_bram_rst", bram_rst_o, 1);
    chk("rst_en", bram_en_o, 0);
    chk("rst_dv", disp_valid_o, 0);
    chk("rst_hv", host_rvalid_o, 0);
    chk("rst_dd", disp_data_o, 0);
    chk("rst_hd", host_rdata_o, 0);
    chk("rst_drop", disp_drop_cnt_o, 0);
    for (int k = 0; k < 8; k++) begin
      exp_dv[cyc+k] = 0; exp_hv[cyc+k] = 0; exp_en[cyc+k] = 0; exp_drop[cyc+k] = 0;
    end
    m_wait = 0; m_drops = 0;
    cyc++;
    reset_i = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = 32'h100 + i;
    do_reset();
    // display-only stream
    tick(1, 32'h10, 0, 0, 0, 0); tick(1, 32'h11, 0, 0, 0, 0); tick(1, 32'h12, 0, 0, 0, 0);
    chk("lit_d0_v", disp_valid_o, 1); chk("lit_d0", disp_data_o, 32'h110);
    idle(1); chk("lit_d1", disp_data_o, 32'h111);
    idle(1); chk("lit_d2", disp_data_o, 32'h112);
    idle(1); chk("lit_d_stable", disp_data_o, 32'h112);
    // host write then read back
    tick(0, 0, 1, 32'h40, 32'hDEADBEEF, 4'hF);
    chk("lit_we", bram_we_o, 4'hF);
    tick(0, 0, 1, 32'h40, 0, 4'h0);
    chk("lit_we_rd", bram_we_o, 4'h0);
    idle(2);
    chk("lit_rv", host_rvalid_o, 1); chk("lit_rd", host_rdata_o, 32'hDEADBEEF);
    tick(0, 0, 1, 32'h41, 32'h0000AB00, 4'h2);
    tick(0, 0, 1, 32'h41, 0, 4'h0);
    idle(3);
    chk("lit_byte_we", host_rdata_o, 32'h0000AB41);
    // starvation
    do_reset();
    first = -1;
    for (int i = 0; i < 9; i++) begin
      tick(1, 32'h20 + i, 1, 32'h80, 0, 0);
      if (last_ready && first < 0) first = i;
    end
    chk("lit_starve_cycle", first, 8);
    chk("lit_drop1", disp_drop_cnt_o, 1);
    idle(4);
    // long display stream with host waiting; STARVE_LIMIT=0 instance must never grant
    nl_ready_cnt = 0;
    for (int i = 0; i < 100; i++) tick(1, i, 1, 32'h90, 0, 0);
    idle(4);
    chk("lit_nl_ready", nl_ready_cnt, 0);
    chk("lit_nl_drop", nl_drop, 0);
    // interleave
    dv_cnt = 0; hv_cnt = 0;
    for (int i = 0; i < 8; i++)
      if (i % 2 == 0) tick(1, 32'h30 + i, 0, 0, 0, 0);
      else tick(0, 0, 1, 32'h50 + i, 0, 0);
    idle(4);
    chk("lit_mix_disp", dv_cnt, 4);
    chk("lit_mix_host", hv_cnt, 4);
    // reset with reads in flight
    tick(1, 32'h14, 0, 0, 0, 0);
    tick(0, 0, 1, 32'h15, 0, 0);
    reset_i = 0; #1;
    chk("lit_async_en", bram_en_o, 0);
    do_reset();
    idle(4);
    tick(1, 32'h12, 0, 0, 0, 0);
    chk("lit_post_rst_en", bram_en_o, 1);
    idle(2);
    chk("lit_post_rst", disp_data_o, 32'h112);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
